// File: rtl/rd_tracker_if.sv
// Bundle between the ID-stage issue/hazard logic and rd_tracker.
// The master side drives issue and decode fields. The slave side publishes the in-flight rd tags.
interface rd_tracker_if #(
  parameter int CNT_W = 16
);
  // Issue handshake: an instruction is accepted on the rising edge where
  // issue_valid=1, stall=0 and flush=0. stall is the inverse of ready, and
  // flush also kills the transfer. Nothing is held across cycles.
  logic             issue_valid;
  logic             issue_regwrite;
  logic [4:0]       issue_rd;
  logic             stall;
  logic             flush;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd_ex_mem;
  logic [4:0]       rd_mem_wb;
  logic [31:0]      pending_mask;
  logic             rs1_busy;
  logic             rs2_busy;
  logic [3:0]       occupancy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output issue_valid, issue_regwrite, issue_rd, stall, flush, rs1, rs2,
    input  rd_ex_mem, rd_mem_wb, pending_mask, rs1_busy, rs2_busy, occupancy, stall_count
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_rd, stall, flush, rs1, rs2,
    output rd_ex_mem, rd_mem_wb, pending_mask, rs1_busy, rs2_busy, occupancy, stall_count
  );
endinterface

// File: rtl/rd_tracker.sv
// Delay line of destination-register tags that mirrors the EX/MEM/WB pipeline.
// It publishes a pending-write mask for the hazard logic and counts stall cycles.
module rd_tracker #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input logic         clock,
  input logic         reset,
  rd_tracker_if.slave bus
);

  logic [DEPTH-1:0] v;
  logic [4:0]       rd_q [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [31:0]      mask;
  logic [3:0]       occ;

  // x0 is never entered, so a valid entry always has a nonzero rd.
  assign accept = bus.issue_valid & bus.issue_regwrite & (bus.issue_rd != 5'd0) &
                  ~bus.stall & ~bus.flush;

  always_ff @(posedge clock) begin
    if (!reset) begin
      v   <= '0;
      cnt <= '0;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= 5'd0;
    end else begin
      v[0]    <= accept;
      rd_q[0] <= accept ? bus.issue_rd : 5'd0;
      // A flush kills the wrong-path instruction that is leaving ID/EX this edge.
      v[1]    <= v[0] & ~bus.flush;
      rd_q[1] <= bus.flush ? 5'd0 : rd_q[0];
      for (int k = 2; k < DEPTH; k++) begin
        v[k]    <= v[k-1];
        rd_q[k] <= rd_q[k-1];
      end
      if (bus.stall && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    mask = '0;
    occ  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (v[k]) begin
        mask[rd_q[k]] = 1'b1;
        occ           = occ + 4'd1;
      end
    end
    mask[0] = 1'b0;
  end

  assign bus.pending_mask = mask;
  assign bus.occupancy    = occ;
  assign bus.rd_ex_mem    = v[0] ? rd_q[0] : 5'd0;
  assign bus.rd_mem_wb    = v[1] ? rd_q[1] : 5'd0;
  assign bus.rs1_busy     = mask[bus.rs1];
  assign bus.rs2_busy     = mask[bus.rs2];
  assign bus.stall_count  = cnt;

endmodule

// File: tb/tb_rd_tracker.sv
// Bench for rd_tracker. Two instances are driven in lockstep: DEPTH=3/CNT_W=16 and DEPTH=4/CNT_W=4.
// A queue model is checked every cycle, and literal expectations pin the model at key points.
module tb_rd_tracker;
  localparam int D0 = 3, C0 = 16, D1 = 4, C1 = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       iv, irw, stl, fl;
  logic [4:0] ird, r1, r2;

  rd_tracker_if #(.CNT_W(C0)) u_if0 ();
  rd_tracker_if #(.CNT_W(C1)) u_if1 ();

  assign u_if0.issue_valid = iv;  assign u_if1.issue_valid = iv;
  assign u_if0.issue_regwrite = irw;  assign u_if1.issue_regwrite = irw;
  assign u_if0.issue_rd = ird;  assign u_if1.issue_rd = ird;
  assign u_if0.stall = stl;  assign u_if1.stall = stl;
  assign u_if0.flush = fl;  assign u_if1.flush = fl;
  assign u_if0.rs1 = r1;  assign u_if1.rs1 = r1;
  assign u_if0.rs2 = r2;  assign u_if1.rs2 = r2;

  rd_tracker #(.DEPTH(D0), .CNT_W(C0)) u_dut0 (.clock(clock), .reset(reset), .bus(u_if0.slave));
  rd_tracker #(.DEPTH(D1), .CNT_W(C1)) u_dut1 (.clock(clock), .reset(reset), .bus(u_if1.slave));

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard
  int n_pass  = 0;
  int n_total = 0;
  bit run_checks = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: each queue holds the rd of every stage, with slot 0 as the youngest.
  // A value of 0 stands for an empty stage.
  logic [4:0] exp_q0[$];
  logic [4:0] exp_q1[$];
  int cnt0, cnt1;

  always @(posedge clock) begin
    logic [4:0] nv;
    if (!reset) begin
      exp_q0.delete();
      exp_q1.delete();
      for (int i = 0; i < D0; i++) exp_q0.push_back(5'd0);
      for (int i = 0; i < D1; i++) exp_q1.push_back(5'd0);
      cnt0 = 0;
      cnt1 = 0;
    end else begin
      nv = (iv && irw && !stl && !fl) ? ird : 5'd0;
      void'(exp_q0.pop_back());
      exp_q0.push_front(nv);
      void'(exp_q1.pop_back());
      exp_q1.push_front(nv);
      if (fl) begin
        exp_q0[1] = 5'd0;
        exp_q1[1] = 5'd0;
      end
      if (stl && cnt0 < (1 << C0) - 1) cnt0++;
      if (stl && cnt1 < (1 << C1) - 1) cnt1++;
    end
  end

  function automatic logic [4:0] q_at(input int which, input int idx);
    return (which == 0) ? exp_q0[idx] : exp_q1[idx];
  endfunction

  function automatic int q_size(input int which);
    return (which == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [31:0] q_mask(input int which);
    logic [31:0] m = '0;
    for (int i = 0; i < q_size(which); i++)
      if (q_at(which, i) != 5'd0) m[q_at(which, i)] = 1'b1;
    return m;
  endfunction

  function automatic int q_occ(input int which);
    int n = 0;
    for (int i = 0; i < q_size(which); i++)
      if (q_at(which, i) != 5'd0) n++;
    return n;
  endfunction

  always @(negedge clock) begin
    if (run_checks) begin
      check("d0_rd_ex_mem", u_if0.rd_ex_mem, q_at(0, 0));
      check("d0_rd_mem_wb", u_if0.rd_mem_wb, q_at(0, 1));
      check("d0_mask", u_if0.pending_mask, q_mask(0));
      check("d0_occ", u_if0.occupancy, q_occ(0));
      check("d0_rs1_busy", u_if0.rs1_busy, q_mask(0) >> r1 & 1);
      check("d0_rs2_busy", u_if0.rs2_busy, q_mask(0) >> r2 & 1);
      check("d0_stall_cnt", u_if0.stall_count, cnt0);
      check("d1_rd_ex_mem", u_if1.rd_ex_mem, q_at(1, 0));
      check("d1_rd_mem_wb", u_if1.rd_mem_wb, q_at(1, 1));
      check("d1_mask", u_if1.pending_mask, q_mask(1));
      check("d1_occ", u_if1.occupancy, q_occ(1));
      check("d1_rs1_busy", u_if1.rs1_busy, q_mask(1) >> r1 & 1);
      check("d1_rs2_busy", u_if1.rs2_busy, q_mask(1) >> r2 & 1);
      check("d1_stall_cnt", u_if1.stall_count, cnt1);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd);
    iv = v; irw = rw; ird = rd; stl = 1'b0; fl = 1'b0;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 5'd0);
    repeat (5) tick();
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, 1'b1, 5'd5);
    r1 = 5'd5; r2 = 5'd0;
    tick();
    run_checks = 1'b1;
    tick();
    check("rst_rd_ex_mem", u_if0.rd_ex_mem, 0);
    check("rst_mask", u_if0.pending_mask, 0);
    check("rst_occ", u_if0.occupancy, 0);
    check("rst_stall_cnt", u_if0.stall_count, 0);
    check("rst_rs1_busy", u_if0.rs1_busy, 0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0);
    tick();

    // single issue of rd=7
    drive(1'b1, 1'b1, 5'd7); r1 = 5'd7;
    tick();
    drive(1'b0, 1'b0, 5'd0);
    check("single_c1_ex_mem", u_if0.rd_ex_mem, 7);
    check("single_c1_busy", u_if0.rs1_busy, 1);
    tick();
    check("single_c2_mem_wb", u_if0.rd_mem_wb, 7);
    check("single_c2_mask7", u_if0.pending_mask[7], 1);
    tick();
    check("single_c3_mask7", u_if0.pending_mask[7], 1);
    check("single_c3_occ", u_if0.occupancy, 1);
    tick();
    check("single_c4_mask7", u_if0.pending_mask[7], 0);
    check("single_c4_busy", u_if0.rs1_busy, 0);
    check("single_c4_d1_mask7", u_if1.pending_mask[7], 1);
    drain();

    // non-writing instruction is not tracked
    drive(1'b1, 1'b0, 5'd8); r1 = 5'd8;
    tick();
    check("nowrite_ex_mem", u_if0.rd_ex_mem, 0);
    drain();

    // flush kills rd=9 in ID/EX and rd=10 in ID
    drive(1'b1, 1'b1, 5'd9); r1 = 5'd9; r2 = 5'd10;
    tick();
    check("flush_c1_ex_mem", u_if0.rd_ex_mem, 9);
    drive(1'b1, 1'b1, 5'd10); fl = 1'b1;
    tick();
    drive(1'b0, 1'b0, 5'd0);
    check("flush_c2_mem_wb", u_if0.rd_mem_wb, 0);
    check("flush_c2_ex_mem", u_if0.rd_ex_mem, 0);
    check("flush_c2_occ", u_if0.occupancy, 0);
    tick();
    check("flush_c3_mask10", u_if0.pending_mask[10], 0);
    drain();

    // duplicates and x0
    r1 = 5'd4; r2 = 5'd0;
    drive(1'b1, 1'b1, 5'd4);
    tick();
    check("dup_c1_mask4", u_if0.pending_mask[4], 1);
    drive(1'b1, 1'b1, 5'd4);
    tick();
    drive(1'b1, 1'b1, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0);
    check("dup_c3_occ", u_if0.occupancy, 2);
    check("dup_c3_mask0", u_if0.pending_mask[0], 0);
    check("dup_c3_rs2_busy", u_if0.rs2_busy, 0);
    tick();
    check("dup_c4_mask4", u_if0.pending_mask[4], 1);
    tick();
    check("dup_c5_mask4", u_if0.pending_mask[4], 0);
    drain();

    // stall blocks rd=3 while rd=12 keeps draining
    r1 = 5'd12; r2 = 5'd3;
    drive(1'b1, 1'b1, 5'd12);
    tick();
    drive(1'b1, 1'b1, 5'd3); stl = 1'b1;
    tick();
    check("stall_c2_ex_mem", u_if0.rd_ex_mem, 0);
    check("stall_c2_mem_wb", u_if0.rd_mem_wb, 12);
    check("stall_c2_mask3", u_if0.pending_mask[3], 0);
    tick();
    tick();
    check("stall_c4_mask3", u_if0.pending_mask[3], 0);
    check("stall_c4_mask12", u_if0.pending_mask[12], 0);
    stl = 1'b0;
    tick();
    drive(1'b0, 1'b0, 5'd0);
    check("stall_c5_ex_mem", u_if0.rd_ex_mem, 3);
    check("stall_cnt3", u_if0.stall_count, 3);
    drain();

    // stall together with flush
    drive(1'b1, 1'b1, 5'd6); r1 = 5'd6; r2 = 5'd11;
    tick();
    drive(1'b1, 1'b1, 5'd11); stl = 1'b1; fl = 1'b1;
    tick();
    drive(1'b0, 1'b0, 5'd0);
    check("sf_ex_mem", u_if0.rd_ex_mem, 0);
    check("sf_mem_wb", u_if0.rd_mem_wb, 0);
    check("sf_stall_cnt", u_if0.stall_count, 4);
    drain();

    // saturation of the 4-bit counter, then a mid-run reset
    stl = 1'b1;
    repeat (20) tick();
    check("sat_d1_cnt", u_if1.stall_count, 15);
    check("sat_d0_cnt", u_if0.stall_count, 24);
    reset = 1'b0;
    tick();
    check("sat_rst_d1", u_if1.stall_count, 0);
    check("sat_rst_d0", u_if0.stall_count, 0);
    reset = 1'b1;
    tick();
    tick();
    check("sat_restart_d1", u_if1.stall_count, 2);
    stl = 1'b0;
    tick();
    tick();

    // final report
    run_checks = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
